// File: rtl/spi_slave_reg_ctrl_pkg.sv
// Shared types and constants for the SPI slave register controller.
// Contents:
//   state_t    - controller FSM states
//   CMD_RD_BIT - command byte bit that selects read (1) or write (0)
//   CMD_ADDR_W - width of the start address field in the command byte
//   addr_t     - 7-bit SPI-side register address
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam int CMD_RD_BIT = 7;
  localparam int CMD_ADDR_W = 7;

  typedef logic [CMD_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/spi_slave_reg_ctrl_cs_sync.sv
// Chip-select synchroniser for the SPI slave register controller.
// Brings the raw, asynchronous CS_n into the i_Clk domain through two flops
// and derives single-cycle edge pulses from the synchronised level.
// Ports:
//   i_Clk   - FPGA clock
//   i_Rst   - asynchronous active-high reset (level resets to 1 = deselected)
//   i_CS_n  - raw SPI chip select
//   o_CS_n  - synchronised chip-select level
//   o_Fall  - 1-cycle pulse on synchronised falling edge (select)
//   o_Rise  - 1-cycle pulse on synchronised rising edge (deselect)
module spi_cs_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_CS_n,
  output logic o_CS_n,
  output logic o_Fall,
  output logic o_Rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_CS_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_CS_n = r_sync;
  assign o_Fall = r_prev & ~r_sync;
  assign o_Rise = ~r_prev & r_sync;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// SPI slave register controller (FPGA-clock side of the byte serializer).
// Turns the received byte stream into register read/write transactions on an
// 8-bit register bank with auto-increment addressing, and supplies the next
// MISO byte to the serializer. Framing comes from the synchronised CS_n.
// Ports:
//   i_Clk, i_Rst              - clock, asynchronous active-high reset
//   i_SPI_CS_n                - raw SPI chip select
//   i_RX_DV, i_RX_Byte        - received byte strobe and data
//   o_TX_DV, o_TX_Byte        - load strobe and data for the next MISO byte
//   i_Host_Wr/Addr/Data       - fabric-side register write port
//   o_Regs                    - flattened register bank, reg n = [8n+7:8n]
//   o_Wr_Strobe, o_Wr_Addr    - pulse and address for each SPI write committed
//   o_Err                     - pulse when a command addresses >= NUM_REGS
//   o_Busy                    - high whenever the controller is not IDLE
module spi_slave_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] TX_DUMMY = 8'hA5,
  parameter int         CS_HOLD  = 4
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_SPI_CS_n,
  input  logic                        i_RX_DV,
  input  logic [7:0]                  i_RX_Byte,
  output logic                        o_TX_DV,
  output logic [7:0]                  o_TX_Byte,
  input  logic                        i_Host_Wr,
  input  logic [$clog2(NUM_REGS)-1:0] i_Host_Addr,
  input  logic [7:0]                  i_Host_Data,
  output logic [NUM_REGS*8-1:0]       o_Regs,
  output logic                        o_Wr_Strobe,
  output logic [6:0]                  o_Wr_Addr,
  output logic                        o_Err,
  output logic                        o_Busy
);

  localparam int              HA_W       = $clog2(NUM_REGS);
  localparam int              HC_W       = $clog2(CS_HOLD + 1);
  localparam addr_t           ADDR_MASK  = addr_t'(NUM_REGS - 1);
  localparam logic [7:0]      NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(CS_HOLD - 1);

  logic       w_cs_n;
  logic       w_fall;
  logic       w_rise;
  addr_t      w_rx_addr;
  state_t     w_cmd_next;
  state_t     w_proc_state;

  state_t          r_state;
  state_t          r_ret_state;
  addr_t           r_addr;
  logic [HC_W-1:0] r_hold_cnt;
  logic [7:0]      r_regs [NUM_REGS];

  spi_cs_sync u_cs_sync (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_CS_n (i_SPI_CS_n),
    .o_CS_n (w_cs_n),
    .o_Fall (w_fall),
    .o_Rise (w_rise)
  );

  function automatic logic in_range(input addr_t a);
    return ({1'b0, a} < NUM_REGS_B);
  endfunction

  // In-range addresses wrap inside the bank; out-of-range ones just count mod 128.
  function automatic addr_t next_addr(input addr_t a);
    addr_t v;
    v = a + 7'd1;
    return in_range(a) ? (v & ADDR_MASK) : v;
  endfunction

  function automatic logic [7:0] rd_data(input addr_t a);
    return in_range(a) ? r_regs[a[HA_W-1:0]] : 8'h00;
  endfunction

  assign w_rx_addr  = i_RX_Byte[CMD_ADDR_W-1:0];
  assign w_cmd_next = i_RX_Byte[CMD_RD_BIT] ? RD : WR;
  // In HOLD a late byte is handled as the state it interrupted.
  assign w_proc_state = (r_state == HOLD) ? r_ret_state : r_state;
  assign o_Busy = (r_state != IDLE);

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_Regs[8*g +: 8] = r_regs[g];
    end
  endgenerate

  // Controller FSM, register bank and all registered outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state     <= IDLE;
      r_ret_state <= IDLE;
      r_addr      <= 7'd0;
      r_hold_cnt  <= '0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= 8'h00;
      o_Wr_Strobe <= 1'b0;
      o_Wr_Addr   <= 7'd0;
      o_Err       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      o_TX_DV     <= 1'b0;
      o_Wr_Strobe <= 1'b0;
      o_Err       <= 1'b0;

      // Host write first so a same-cycle SPI write to the same register overrides it.
      if (i_Host_Wr) begin
        r_regs[i_Host_Addr] <= i_Host_Data;
      end

      if (i_RX_DV && (r_state != IDLE)) begin
        case (w_proc_state)
          CMD: begin
            if (!in_range(w_rx_addr)) begin
              o_Err <= 1'b1;
            end
            if (i_RX_Byte[CMD_RD_BIT]) begin
              o_TX_DV   <= 1'b1;
              o_TX_Byte <= rd_data(w_rx_addr);
              r_addr    <= next_addr(w_rx_addr);
            end else begin
              r_addr <= w_rx_addr;
            end
          end
          WR: begin
            if (in_range(r_addr)) begin
              r_regs[r_addr[HA_W-1:0]] <= i_RX_Byte;
              o_Wr_Strobe <= 1'b1;
              o_Wr_Addr   <= r_addr;
            end
            r_addr <= next_addr(r_addr);
          end
          RD: begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= rd_data(r_addr);
            r_addr    <= next_addr(r_addr);
          end
          default: begin
            r_addr <= r_addr;
          end
        endcase
      end

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= TX_DUMMY;
            r_state   <= CMD;
          end
        end
        CMD: begin
          // Level term guards against a deselect whose rise pulse was not seen here.
          if (w_rise || w_cs_n) begin
            r_state     <= HOLD;
            r_ret_state <= i_RX_DV ? w_cmd_next : CMD;
            r_hold_cnt  <= '0;
          end else if (i_RX_DV) begin
            r_state <= w_cmd_next;
          end
        end
        WR, RD: begin
          if (w_rise || w_cs_n) begin
            r_state     <= HOLD;
            r_ret_state <= r_state;
            r_hold_cnt  <= '0;
          end
        end
        HOLD: begin
          if (w_fall) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= TX_DUMMY;
            r_state   <= CMD;
          end else begin
            if (i_RX_DV && (r_ret_state == CMD)) begin
              r_ret_state <= w_cmd_next;
            end
            if (r_hold_cnt == HOLD_LAST) begin
              r_state <= IDLE;
            end else begin
              r_hold_cnt <= r_hold_cnt + HC_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed self-checking bench for spi_slave_reg_ctrl (NUM_REGS=16, CS_HOLD=4).
module tb_spi_slave_reg_ctrl;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic         i_SPI_CS_n;
  logic         i_RX_DV;
  logic [7:0]   i_RX_Byte;
  logic         o_TX_DV;
  logic [7:0]   o_TX_Byte;
  logic         i_Host_Wr;
  logic [3:0]   i_Host_Addr;
  logic [7:0]   i_Host_Data;
  logic [127:0] o_Regs;
  logic         o_Wr_Strobe;
  logic [6:0]   o_Wr_Addr;
  logic         o_Err;
  logic         o_Busy;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int strobe_before;
  int err_before;
  logic [7:0] exp_regs [16];

  spi_slave_reg_ctrl #(
    .NUM_REGS (16),
    .TX_DUMMY (8'hA5),
    .CS_HOLD  (4)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_SPI_CS_n  (i_SPI_CS_n),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_Host_Wr   (i_Host_Wr),
    .i_Host_Addr (i_Host_Addr),
    .i_Host_Data (i_Host_Data),
    .o_Regs      (o_Regs),
    .o_Wr_Strobe (o_Wr_Strobe),
    .o_Wr_Addr   (o_Wr_Addr),
    .o_Err       (o_Err),
    .o_Busy      (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge i_Clk) begin
    if (o_Wr_Strobe === 1'b1) strobe_cnt++;
    if (o_Err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  function automatic logic [7:0] reg_of(input int n);
    return o_Regs[8*n +: 8];
  endfunction

  function automatic logic [127:0] exp_flat();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  task automatic cs_fall();
    i_SPI_CS_n = 1'b0;
    tick(3);
    check("dummy_dv", o_TX_DV, 1'b1);
    check("dummy_byte", o_TX_Byte, 8'hA5);
    check("busy_on", o_Busy, 1'b1);
  endtask

  task automatic cs_rise();
    i_SPI_CS_n = 1'b1;
    tick(8);
    check("busy_off", o_Busy, 1'b0);
  endtask

  // Byte is processed at the next edge; outputs checked right after it.
  task automatic send(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    tick(1);
    i_RX_DV   = 1'b0;
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    i_Host_Wr   = 1'b1;
    i_Host_Addr = a;
    i_Host_Data = d;
    tick(1);
    i_Host_Wr   = 1'b0;
    exp_regs[a] = d;
  endtask

  initial begin
    i_Rst = 1'b1; i_SPI_CS_n = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
    i_Host_Wr = 1'b0; i_Host_Addr = 4'd0; i_Host_Data = 8'h00;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    tick(3);
    check("rst_regs", o_Regs, 128'd0);
    check("rst_busy", o_Busy, 1'b0);
    check("rst_txdv", o_TX_DV, 1'b0);
    check("rst_txbyte", o_TX_Byte, 8'h00);
    check("rst_strobe", o_Wr_Strobe, 1'b0);
    i_Rst = 1'b0;
    tick(2);

    // 1: write 11,22 from address 3
    strobe_before = strobe_cnt; err_before = err_cnt;
    cs_fall();
    send(8'h03);
    check("t1_cmd_nostrobe", o_Wr_Strobe, 1'b0);
    send(8'h11);
    check("t1_strobe0", o_Wr_Strobe, 1'b1);
    check("t1_addr0", o_Wr_Addr, 7'd3);
    check("t1_reg3", reg_of(3), 8'h11);
    send(8'h22);
    check("t1_strobe1", o_Wr_Strobe, 1'b1);
    check("t1_addr1", o_Wr_Addr, 7'd4);
    check("t1_reg4", reg_of(4), 8'h22);
    exp_regs[3] = 8'h11; exp_regs[4] = 8'h22;
    cs_rise();
    check("t1_nstrobe", strobe_cnt - strobe_before, 2);
    check("t1_noerr", err_cnt - err_before, 0);

    // 2: burst read from address 5
    host_wr(4'd5, 8'h5A);
    host_wr(4'd6, 8'h6B);
    host_wr(4'd7, 8'hC3);
    cs_fall();
    send(8'h85);
    check("t2_dv0", o_TX_DV, 1'b1);
    check("t2_rd5", o_TX_Byte, 8'h5A);
    tick(1);
    check("t2_dv_single", o_TX_DV, 1'b0);
    send(8'h00);
    check("t2_rd6", o_TX_Byte, 8'h6B);
    send(8'h00);
    check("t2_rd7", o_TX_Byte, 8'hC3);
    cs_rise();

    // 3: write wraps from 15 to 0
    cs_fall();
    send(8'h0F);
    send(8'h01);
    check("t3_addr15", o_Wr_Addr, 7'd15);
    send(8'h02);
    check("t3_addr_wrap", o_Wr_Addr, 7'd0);
    exp_regs[15] = 8'h01; exp_regs[0] = 8'h02;
    check("t3_reg15", reg_of(15), 8'h01);
    check("t3_reg0", reg_of(0), 8'h02);
    cs_rise();

    // 4: read from out-of-range address 20
    err_before = err_cnt;
    cs_fall();
    send(8'h94);
    check("t4_err", o_Err, 1'b1);
    check("t4_dv", o_TX_DV, 1'b1);
    check("t4_byte", o_TX_Byte, 8'h00);
    cs_rise();
    check("t4_err_cnt", err_cnt - err_before, 1);
    check("t4_regs", o_Regs, exp_flat());

    // 5: host/SPI collision on reg2, then independent writes
    cs_fall();
    send(8'h02);
    i_Host_Wr = 1'b1; i_Host_Addr = 4'd2; i_Host_Data = 8'hFF;
    send(8'h33);
    i_Host_Wr = 1'b0;
    exp_regs[2] = 8'h33;
    check("t5_reg2_spi_wins", reg_of(2), 8'h33);
    i_Host_Wr = 1'b1; i_Host_Addr = 4'd10; i_Host_Data = 8'h10;
    send(8'h44);
    i_Host_Wr = 1'b0;
    exp_regs[3] = 8'h44; exp_regs[10] = 8'h10;
    check("t5_both_spi", reg_of(3), 8'h44);
    check("t5_both_host", reg_of(10), 8'h10);
    cs_rise();
    host_wr(4'd9, 8'h77);
    check("t5_reg9", reg_of(9), 8'h77);
    check("t5_regs", o_Regs, exp_flat());

    // 6: late byte 3 cycles after synced CS rise is still committed
    cs_fall();
    send(8'h08);
    send(8'hAB);
    i_SPI_CS_n = 1'b1;
    tick(2);
    tick(3);
    send(8'hCD);
    check("t6_late_strobe", o_Wr_Strobe, 1'b1);
    check("t6_late_addr", o_Wr_Addr, 7'd9);
    exp_regs[8] = 8'hAB; exp_regs[9] = 8'hCD;
    tick(1);
    check("t6_idle", o_Busy, 1'b0);
    check("t6_regs", o_Regs, exp_flat());

    // 6b: reset mid-write aborts the transaction
    cs_fall();
    send(8'h0A);
    send(8'hEE);
    check("t6_pre_rst_reg10", reg_of(10), 8'hEE);
    i_Rst = 1'b1;
    #1;
    check("t6_rst_regs", o_Regs, 128'd0);
    check("t6_rst_busy", o_Busy, 1'b0);
    i_SPI_CS_n = 1'b1;
    tick(2);
    i_Rst = 1'b0;
    strobe_before = strobe_cnt;
    send(8'h55);
    tick(10);
    check("t6_no_strobe", strobe_cnt - strobe_before, 0);
    check("t6_still_idle", o_Busy, 1'b0);
    check("t6_regs_zero", o_Regs, 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
